// File: rtl/mult8_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// mult8_seq_ctrl_if : operand/result handshakes plus the external 4x4 core port
// Rev 1.0
// ============================================================================
interface mult8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] R;
  logic [3:0]  core_A;
  logic [3:0]  core_B;
  logic [7:0]  core_R;

  modport slave (
    input  in_valid, A, B, out_ready, core_R,
    output in_ready, out_valid, R, core_A, core_B
  );

  modport master (
    output in_valid, A, B, out_ready, core_R,
    input  in_ready, out_valid, R, core_A, core_B
  );
endinterface
`default_nettype wire

// File: rtl/mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// mult8_seq_ctrl : 8x8 unsigned product from four passes of an external 4x4 core
// Rev 1.0
// ============================================================================
module mult8_seq_ctrl #(
  parameter bit SKIP_LL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  mult8_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PP0  = 3'd1,
    S_PP1  = 3'd2,
    S_PP2  = 3'd3,
    S_PP3  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc_q;
  logic [15:0] r_q;
  logic        out_valid_q;

  logic [3:0]  core_a;
  logic [3:0]  core_b;
  logic [15:0] addend;
  logic [15:0] acc_d;

  // Nibble selection and alignment of the partial product for the current pass
  always_comb begin
    core_a = 4'h0;
    core_b = 4'h0;
    addend = 16'h0000;
    case (state_q)
      S_PP0: begin
        core_a = a_q[3:0];
        core_b = b_q[3:0];
        addend = {8'h00, bus.core_R};
      end
      S_PP1: begin
        core_a = a_q[7:4];
        core_b = b_q[3:0];
        addend = {4'h0, bus.core_R, 4'h0};
      end
      S_PP2: begin
        core_a = a_q[3:0];
        core_b = b_q[7:4];
        addend = {4'h0, bus.core_R, 4'h0};
      end
      S_PP3: begin
        core_a = a_q[7:4];
        core_b = b_q[7:4];
        addend = {bus.core_R, 8'h00};
      end
      default: ;
    endcase
  end

  // Modulo-2^16 on purpose: approximate cores may overshoot and simply wrap
  assign acc_d = acc_q + addend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      acc_q       <= 16'h0000;
      r_q         <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            acc_q   <= 16'h0000;
            state_q <= SKIP_LL ? S_PP1 : S_PP0;
          end
        end
        S_PP0: begin
          acc_q   <= acc_d;
          state_q <= S_PP1;
        end
        S_PP1: begin
          acc_q   <= acc_d;
          state_q <= S_PP2;
        end
        S_PP2: begin
          acc_q   <= acc_d;
          state_q <= S_PP3;
        end
        S_PP3: begin
          acc_q       <= acc_d;
          r_q         <= acc_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Gated by rst so no operand can appear accepted while reset is held
  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.R         = r_q;
  assign bus.core_A    = core_a;
  assign bus.core_B    = core_b;

endmodule
`default_nettype wire
